regfile_scoreboard: RTL and testbench
=====================================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter WIDTH, default 32, data bits per register.
REQ-002 Parameter DEPTH, default 32, number of registers, power of two, >= 2.
REQ-003 Parameter BYPASS, default 1, when 1 same-cycle write data and busy-clear are forwarded to read ports.
REQ-004 Derived AW = clog2(DEPTH), address width.
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 we  input  1  write-back enable.
REQ-008 waddr  input  AW  write-back register index.
REQ-009 wdata  input  WIDTH  write-back data.
REQ-010 ra1, ra2  input  AW each  read-port indices.
REQ-011 rd1, rd2  output  WIDTH each  read data.
REQ-012 iss_en  input  1  issue: mark destination register pending.
REQ-013 iss_addr  input  AW  destination index of issued instruction.
REQ-014 busy1, busy2  output  1 each  pending status of ra1, ra2.

Function
REQ-015 Register 0 SHALL read as 0 and never be busy; writes and issues to index 0 SHALL be ignored.
REQ-016 On rising edge with we=1, waddr!=0: reg[waddr] <= wdata; latency 1 cycle to unbypassed read.
REQ-017 Reads SHALL be combinational from ra1/ra2; no read enable.
REQ-018 BYPASS=1: if we=1, waddr==raN, waddr!=0, rdN SHALL equal wdata in the same cycle; BYPASS=0: rdN shows old value until next edge.
REQ-019 Busy bit per register: iss_en=1, iss_addr!=0 sets busy[iss_addr] at edge.
REQ-020 we=1, waddr!=0 clears busy[waddr] at edge.
REQ-021 Simultaneous issue and write-back to the same index: data SHALL be written AND busy SHALL end set (new producer wins).
REQ-022 BYPASS=1: busyN SHALL read 0 in a cycle where we=1 and waddr==raN (unless iss_en targets same index, which does not affect the current-cycle output).
REQ-023 BYPASS=0: busyN reflects registered busy bit only.
REQ-024 Both read ports SHALL be independent; ra1==ra2 returns identical data/busy.
REQ-025 Write-back to a non-busy register SHALL still update data; busy stays 0.
REQ-026 Out-of-range indices cannot occur (DEPTH power of two); no error signalling.

Reset
REQ-027 reset=1 at an edge SHALL clear all registers to 0 and all busy bits to 0.
REQ-028 we and iss_en SHALL be ignored in any cycle with reset=1, including mid-operation.
REQ-029 While reset=1, rd1/rd2 and busy1/busy2 SHALL reflect stored state (bypass suppressed); after first reset edge all read 0.

Structure
REQ-030 Shared package regfile_pkg SHALL hold default WIDTH, DEPTH, BYPASS constants and the AW clog2 function.
REQ-031 One sub-module regw_en (WIDTH-bit enabled register, sync reset) SHALL be instantiated DEPTH-1 times; register 0 has no storage.
REQ-032 Busy vector SHALL be a single DEPTH-bit register in the top module.

Verification
REQ-033 Reset, then read all indices -> rd=0, busy=0 for every index.
REQ-034 we=1, waddr=5, wdata=0xDEADBEEF, ra1=5 same cycle -> BYPASS=1: rd1=0xDEADBEEF same cycle; BYPASS=0: next cycle.
REQ-035 we=1, waddr=0, wdata=0xFFFFFFFF; iss_en=1, iss_addr=0 -> rd1(ra1=0)=0, busy1=0 thereafter.
REQ-036 iss_en=1, iss_addr=7; next cycle ra2=7 -> busy2=1; we=1, waddr=7, wdata=0x12 -> busy2=0 same cycle (BYPASS=1), rd2=0x12; next cycle busy2=0.
REQ-037 Same cycle iss_en=1, iss_addr=9 and we=1, waddr=9, wdata=0x55 -> next cycle rd1(ra1=9)=0x55, busy1=1.
REQ-038 Write 0xA5 to reg 3, issue reg 3, then reset=1 with we=1, waddr=3, wdata=0x77 -> after edge rd(3)=0, busy(3)=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and the address-width helper for the register file scoreboard.
package regfile_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_DEPTH  = 32;
    localparam bit DEF_BYPASS = 1'b1;

    // Smallest r with 2**r >= n; n is a power of two >= 2.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/regw_en.sv
// WIDTH-bit storage register with write enable and synchronous active-high reset.
module regw_en
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;

    // Storage update: reset has priority over the enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= {WIDTH{1'b0}};
        end else if (en) begin
            q_q <= d;
        end else begin
            q_q <= q_q;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending (busy) bits, two combinational read
// ports and optional same-cycle forwarding of write-back data and busy-clear.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter bit BYPASS = DEF_BYPASS,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_addr,
    output logic             busy1,
    output logic             busy2
);

    logic [WIDTH-1:0] reg_q [DEPTH];
    logic [DEPTH-1:0] wr_en_s;
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             wb_live_s;
    logic             iss_live_s;
    logic             hit1_s;
    logic             hit2_s;

    // Index 0 is hardwired to zero and never stored.
    assign reg_q[0] = {WIDTH{1'b0}};

    assign wb_live_s  = we && !reset && (waddr != {AW{1'b0}});
    assign iss_live_s = iss_en && !reset && (iss_addr != {AW{1'b0}});

    // One-hot write select for the data registers.
    always_comb begin
        wr_en_s = {DEPTH{1'b0}};
        if (wb_live_s) begin
            wr_en_s[waddr] = 1'b1;
        end else begin
            wr_en_s = {DEPTH{1'b0}};
        end
        wr_en_s[0] = 1'b0;
    end

    for (genvar i = 1; i < DEPTH; i++) begin : g_reg
        regw_en #(
            .WIDTH(WIDTH)
        ) u_reg (
            .clk  (clk),
            .reset(reset),
            .en   (wr_en_s[i]),
            .d    (wdata),
            .q    (reg_q[i])
        );
    end

    // Busy next state: write-back clears first so a same-index issue wins.
    always_comb begin
        busy_d = busy_q;
        if (wb_live_s) begin
            busy_d[waddr] = 1'b0;
        end else begin
            busy_d = busy_q;
        end
        if (iss_live_s) begin
            busy_d[iss_addr] = 1'b1;
        end else begin
            busy_d[0] = 1'b0;
        end
        busy_d[0] = 1'b0;
    end

    // Busy vector register.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= {DEPTH{1'b0}};
        end else begin
            busy_q <= busy_d;
        end
    end

    // Read ports; forwarding is suppressed while reset is asserted.
    always_comb begin
        hit1_s = 1'b0;
        hit2_s = 1'b0;
        if (BYPASS && wb_live_s) begin
            hit1_s = (waddr == ra1);
            hit2_s = (waddr == ra2);
        end else begin
            hit1_s = 1'b0;
            hit2_s = 1'b0;
        end
        rd1   = hit1_s ? wdata : reg_q[ra1];
        rd2   = hit2_s ? wdata : reg_q[ra2];
        busy1 = busy_q[ra1] & ~hit1_s;
        busy2 = busy_q[ra2] & ~hit2_s;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized scoreboard bench for regfile_scoreboard with an array-based reference model.
module tb_regfile_scoreboard;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          we;
    logic [AW-1:0] waddr;
    logic [W-1:0]  wdata;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [W-1:0]  rd1;
    logic [W-1:0]  rd2;
    logic          iss_en;
    logic [AW-1:0] iss_addr;
    logic          busy1;
    logic          busy2;

    regfile_scoreboard #(.WIDTH(W), .DEPTH(D), .BYPASS(1'b1)) dut (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .ra1     (ra1),
        .ra2     (ra2),
        .rd1     (rd1),
        .rd2     (rd2),
        .iss_en  (iss_en),
        .iss_addr(iss_addr),
        .busy1   (busy1),
        .busy2   (busy2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] rd1;
        logic         b1;
        logic [W-1:0] rd2;
        logic         b2;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] mem [D];
    logic         pend [D];
    int           total = 0;
    int           bad = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, want, $time);
        end
    endtask

    // Monitor: outputs are combinational, so one expectation per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rd1",   rd1, e.rd1);
            check("busy1", {31'd0, busy1}, {31'd0, e.b1});
            check("rd2",   rd2, e.rd2);
            check("busy2", {31'd0, busy2}, {31'd0, e.b2});
        end
    end

    // Drive one cycle, predict its outputs from the model, then advance the model past the edge.
    task automatic step(input logic rst, input logic w, input int wa, input logic [W-1:0] wd,
                        input int r1, input int r2, input logic is, input int ia, input bit chk);
        exp_t e;
        bit   fwd1, fwd2;
        reset = rst; we = w; waddr = AW'(wa); wdata = wd;
        ra1 = AW'(r1); ra2 = AW'(r2); iss_en = is; iss_addr = AW'(ia);
        fwd1 = !rst && w && wa != 0 && wa == r1;
        fwd2 = !rst && w && wa != 0 && wa == r2;
        e.rd1 = fwd1 ? wd : mem[r1];
        e.b1  = fwd1 ? 1'b0 : pend[r1];
        e.rd2 = fwd2 ? wd : mem[r2];
        e.b2  = fwd2 ? 1'b0 : pend[r2];
        if (chk) exp_q.push_back(e);
        if (rst) begin
            for (int k = 0; k < D; k++) begin
                mem[k] = '0;
                pend[k] = 1'b0;
            end
        end else begin
            if (w && wa != 0) begin
                mem[wa] = wd;
                pend[wa] = 1'b0;
            end
            if (is && ia != 0) pend[ia] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        ra1 = '0; ra2 = '0; iss_en = 1'b0; iss_addr = '0;
        for (int k = 0; k < D; k++) begin
            mem[k] = '0;
            pend[k] = 1'b0;
        end
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 0, 32'h0, 0, 0, 1'b0, 0, 1'b0);
        step(1'b1, 1'b1, 4, 32'h1234_5678, 4, 4, 1'b1, 4, 1'b1);
        // Every index reads zero and idle after reset.
        for (int i = 0; i < D; i++) step(1'b0, 1'b0, 0, 32'h0, i, D - 1 - i, 1'b0, 0, 1'b1);
        // Same-cycle forwarding of a write.
        step(1'b0, 1'b1, 5, 32'hDEAD_BEEF, 5, 0, 1'b0, 0, 1'b1);
        step(1'b0, 1'b0, 0, 32'h0, 5, 5, 1'b0, 0, 1'b1);
        // Index 0 ignores writes and issues.
        step(1'b0, 1'b1, 0, 32'hFFFF_FFFF, 0, 0, 1'b1, 0, 1'b1);
        step(1'b0, 1'b0, 0, 32'h0, 0, 0, 1'b0, 0, 1'b1);
        // Issue, busy seen, write-back clears busy in the same cycle.
        step(1'b0, 1'b0, 0, 32'h0, 0, 7, 1'b1, 7, 1'b1);
        step(1'b0, 1'b0, 0, 32'h0, 0, 7, 1'b0, 0, 1'b1);
        step(1'b0, 1'b1, 7, 32'h12, 0, 7, 1'b0, 0, 1'b1);
        step(1'b0, 1'b0, 0, 32'h0, 7, 7, 1'b0, 0, 1'b1);
        // Simultaneous issue and write-back: data lands, busy stays set.
        step(1'b0, 1'b1, 9, 32'h55, 0, 0, 1'b1, 9, 1'b1);
        step(1'b0, 1'b0, 0, 32'h0, 9, 9, 1'b0, 0, 1'b1);
        // Reset overrides a concurrent write; stored state visible while reset is high.
        step(1'b0, 1'b1, 3, 32'hA5, 0, 0, 1'b0, 0, 1'b1);
        step(1'b0, 1'b0, 0, 32'h0, 3, 0, 1'b1, 3, 1'b1);
        step(1'b1, 1'b1, 3, 32'h77, 3, 3, 1'b0, 0, 1'b1);
        step(1'b0, 1'b0, 0, 32'h0, 3, 3, 1'b0, 0, 1'b1);
        // Random traffic concentrated on a few indices to provoke collisions.
        for (int n = 0; n < 600; n++) begin
            int hi;
            hi = ($urandom_range(0, 3) == 0) ? D - 1 : 7;
            step(($urandom_range(0, 60) == 0), 1'($urandom_range(0, 1)), $urandom_range(0, hi),
                 $urandom, $urandom_range(0, hi), $urandom_range(0, hi),
                 1'($urandom_range(0, 1)), $urandom_range(0, hi), 1'b1);
        end
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain got=%0d want=0 pending expectations", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
